// File: rtl/pair_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pair_pkg
// Description : Definitions shared by the pair store/display block.
//               Contents:
//                 - FSM state encoding (COLLECT / REVIEW)
//                 - storage depth
//                 - stored-pair record type
//                 - seven-segment glyph table and blank/fixed codes
// Revision    : 1.0 - initial release
// ============================================================================
package pair_pkg;

    // Number of pair slots.
    localparam int c_depth = 4;

    // FSM state encoding: one bit, so the state register doubles as the mode output.
    localparam logic [0:0] c_st_collect = 1'b0;
    localparam logic [0:0] c_st_review  = 1'b1;

    // One stored pair: X in the upper nibble, Y in the lower nibble.
    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
    } pair_t;

    // Active-low display codes used directly by the output registers.
    localparam logic [6:0] c_seg_blank = 7'h7F;  // all segments off
    localparam logic [6:0] c_seg_c     = 7'h46;  // "C"
    localparam logic [6:0] c_seg_zero  = 7'h40;  // "0"

    // Nibble that decodes to the "C" glyph.
    localparam logic [3:0] c_nib_c = 4'hC;

    // Active-high segment pattern for one hex digit.
    // Bit 0 is segment a and bit 6 is segment g.
    function automatic logic [6:0] seg_on(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h67;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hex_to_seg7.sv
`default_nettype none
// ============================================================================
// Module      : hex_to_seg7
// Description : Combinational decode of one hex nibble into an active-low
//               seven-segment pattern.
//               Ports:
//                 i_hex  in   4  value to show
//                 o_seg  out  7  segments, active-low, bit0=a ... bit6=g
// Revision    : 1.0 - initial release
// ============================================================================
module hex_to_seg7
    import pair_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = ~seg_on(i_hex);
    end

endmodule
`default_nettype wire

// File: rtl/pair_store_display.sv
`default_nettype none
// ============================================================================
// Module      : pair_store_display
// Description : Collects up to four (X,Y) nibble pairs, then cycles through
//               them showing each pair and its sum on six seven-segment digits.
//               Ports:
//                 clock, reset      single clock, synchronous active-high reset
//                 in_valid          one-cycle pair strobe
//                 in_x, in_y        entered pair; (0,0) is the terminator
//                 H1..H6            active-low digits, H6 leftmost
//                 mode              0=COLLECT, 1=REVIEW
//                 count             number of stored pairs (0-4)
// Revision    : 1.0 - initial release
// ============================================================================
module pair_store_display
    import pair_pkg::*;
#(
    parameter int DWELL_CYCLES = 50000000
)(
    input  logic       clock,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [3:0] in_x,
    input  logic [3:0] in_y,
    output logic [6:0] H1,
    output logic [6:0] H2,
    output logic [6:0] H3,
    output logic [6:0] H4,
    output logic [6:0] H5,
    output logic [6:0] H6,
    output logic       mode,
    output logic [2:0] count
);

    localparam logic [25:0] c_dwell_last = 26'(DWELL_CYCLES - 1);

    logic [0:0]  r_state;
    logic [2:0]  r_count;
    logic [1:0]  r_idx;
    logic [25:0] r_dwell;
    pair_t       r_slot [c_depth];
    logic [6:0]  r_h    [6];

    logic [0:0]  w_state_nxt;
    logic [2:0]  w_count_nxt;
    logic [1:0]  w_idx_nxt;
    logic [25:0] w_dwell_nxt;
    logic        w_wr_en;
    logic        w_term;
    logic        w_data;
    logic [1:0]  w_last_idx;

    // Digit arrays are indexed 0..5 for H1..H6.
    logic [3:0]  w_nib   [6];
    logic        w_blank [6];
    logic [6:0]  w_seg   [6];
    pair_t       w_last;
    pair_t       w_cur;
    logic [4:0]  w_sum;

    assign w_term     = in_valid && (in_x == 4'h0) && (in_y == 4'h0);
    assign w_data     = in_valid && !w_term;
    // Slot of the most recent pair; count is never 0 when this is used in REVIEW.
    assign w_last_idx = 2'(r_count - 3'd1);

    // ------------------------------------------------------------------
    // State register, counters and slot storage
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_st_collect;
            r_count <= 3'd0;
            r_idx   <= 2'd0;
            r_dwell <= 26'd0;
            for (int i = 0; i < c_depth; i++) begin
                r_slot[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_idx   <= w_idx_nxt;
            r_dwell <= w_dwell_nxt;
            if (w_wr_en) begin
                r_slot[r_count[1:0]] <= '{x: in_x, y: in_y};
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_idx_nxt   = r_idx;
        w_dwell_nxt = r_dwell;
        w_wr_en     = 1'b0;
        case (r_state)
            c_st_collect: begin
                // A full store moves to REVIEW on the edge after the 4th write,
                // whatever arrives in that cycle.
                if (r_count == 3'(c_depth)) begin
                    w_state_nxt = c_st_review;
                    w_idx_nxt   = 2'd0;
                    w_dwell_nxt = 26'd0;
                end else if (w_data) begin
                    w_wr_en     = 1'b1;
                    w_count_nxt = r_count + 3'd1;
                end else if (w_term && (r_count != 3'd0)) begin
                    w_state_nxt = c_st_review;
                    w_idx_nxt   = 2'd0;
                    w_dwell_nxt = 26'd0;
                end
            end
            c_st_review: begin
                if (w_term) begin
                    w_state_nxt = c_st_collect;
                    w_count_nxt = 3'd0;
                    w_idx_nxt   = 2'd0;
                    w_dwell_nxt = 26'd0;
                end else if (r_dwell == c_dwell_last) begin
                    w_dwell_nxt = 26'd0;
                    w_idx_nxt   = (r_idx == w_last_idx) ? 2'd0 : r_idx + 2'd1;
                end else begin
                    w_dwell_nxt = r_dwell + 26'd1;
                end
            end
            default: begin
                w_state_nxt = c_st_collect;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: digit values and blanking from the current state
    // ------------------------------------------------------------------
    assign w_last = r_slot[w_last_idx];
    assign w_cur  = r_slot[r_idx];
    assign w_sum  = {1'b0, w_cur.x} + {1'b0, w_cur.y};

    always_comb begin
        for (int i = 0; i < 6; i++) begin
            w_nib[i]   = 4'h0;
            w_blank[i] = 1'b1;
        end
        w_nib[4]   = {1'b0, r_count};
        w_blank[4] = 1'b0;
        if (r_state == c_st_review) begin
            w_nib[5]   = {2'b00, r_idx};
            w_nib[3]   = w_cur.x;
            w_nib[2]   = w_cur.y;
            w_nib[1]   = {3'b000, w_sum[4]};
            w_nib[0]   = w_sum[3:0];
            w_blank[5] = 1'b0;
            w_blank[3] = 1'b0;
            w_blank[2] = 1'b0;
            w_blank[1] = 1'b0;
            w_blank[0] = 1'b0;
        end else begin
            w_nib[5]   = c_nib_c;
            w_blank[5] = 1'b0;
            w_nib[3]   = w_last.x;
            w_nib[2]   = w_last.y;
            w_blank[3] = (r_count == 3'd0);
            w_blank[2] = (r_count == 3'd0);
        end
    end

    for (genvar g = 0; g < 6; g++) begin : g_digit
        hex_to_seg7 u_dec (
            .i_hex (w_nib[g]),
            .o_seg (w_seg[g])
        );
    end

    // Registered display: lags the state registers by one edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_h[5] <= c_seg_c;
            r_h[4] <= c_seg_zero;
            for (int i = 0; i < 4; i++) begin
                r_h[i] <= c_seg_blank;
            end
        end else begin
            for (int i = 0; i < 6; i++) begin
                r_h[i] <= w_blank[i] ? c_seg_blank : w_seg[i];
            end
        end
    end

    assign H1    = r_h[0];
    assign H2    = r_h[1];
    assign H3    = r_h[2];
    assign H4    = r_h[3];
    assign H5    = r_h[4];
    assign H6    = r_h[5];
    assign mode  = r_state;
    assign count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_pair_store_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_pair_store_display
// Description : Directed self-checking bench for pair_store_display with a
//               four-cycle dwell. Expected segment codes are hand-derived
//               active-low glyphs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pair_store_display;

    logic       clock;
    logic       reset;
    logic       in_valid;
    logic [3:0] in_x;
    logic [3:0] in_y;
    logic [6:0] H1, H2, H3, H4, H5, H6;
    logic       mode;
    logic [2:0] count;

    int n_vec;
    int n_err;

    pair_store_display #(
        .DWELL_CYCLES (4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_x     (in_x),
        .in_y     (in_y),
        .H1       (H1),
        .H2       (H2),
        .H3       (H3),
        .H4       (H4),
        .H5       (H5),
        .H6       (H6),
        .mode     (mode),
        .count    (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance n edges; sample 1 time unit after the last edge.
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Present one pair for exactly one edge.
    task automatic strobe(input logic [3:0] x, input logic [3:0] y);
        in_valid = 1'b1;
        in_x     = x;
        in_y     = y;
        step(1);
        in_valid = 1'b0;
        in_x     = 4'h0;
        in_y     = 4'h0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_x     = 4'h0;
        in_y     = 4'h0;
        do_reset();

        // Reset state
        check_eq("rst_mode",  {7'd0, mode},  8'h00);
        check_eq("rst_count", {5'd0, count}, 8'h00);
        check_eq("rst_H6",    {1'b0, H6},    8'h46);
        check_eq("rst_H5",    {1'b0, H5},    8'h40);
        check_eq("rst_H4",    {1'b0, H4},    8'h7F);
        check_eq("rst_H1",    {1'b0, H1},    8'h7F);

        // One pair in COLLECT
        strobe(4'h3, 4'h5);
        check_eq("c1_count", {5'd0, count}, 8'h01);
        step(1);
        check_eq("c1_H6", {1'b0, H6}, 8'h46);
        check_eq("c1_H5", {1'b0, H5}, 8'h79);
        check_eq("c1_H4", {1'b0, H4}, 8'h30);
        check_eq("c1_H3", {1'b0, H3}, 8'h12);
        check_eq("c1_H2", {1'b0, H2}, 8'h7F);

        // Two pairs then terminator; review alternates between them
        do_reset();
        strobe(4'h1, 4'h2);
        strobe(4'hA, 4'hF);
        check_eq("t_count", {5'd0, count}, 8'h02);
        strobe(4'h0, 4'h0);
        check_eq("t_mode", {7'd0, mode}, 8'h01);
        step(1);
        check_eq("r0_H6", {1'b0, H6}, 8'h40);
        check_eq("r0_H5", {1'b0, H5}, 8'h24);
        check_eq("r0_H4", {1'b0, H4}, 8'h79);
        check_eq("r0_H3", {1'b0, H3}, 8'h24);
        check_eq("r0_H2", {1'b0, H2}, 8'h40);
        check_eq("r0_H1", {1'b0, H1}, 8'h30);
        step(3);
        check_eq("r0_hold_H6", {1'b0, H6}, 8'h40);
        step(1);
        check_eq("r1_H6", {1'b0, H6}, 8'h79);
        check_eq("r1_H4", {1'b0, H4}, 8'h08);
        check_eq("r1_H3", {1'b0, H3}, 8'h0E);
        check_eq("r1_H2", {1'b0, H2}, 8'h79);
        check_eq("r1_H1", {1'b0, H1}, 8'h18);
        step(4);
        check_eq("rwrap_H6", {1'b0, H6}, 8'h40);
        check_eq("rwrap_H1", {1'b0, H1}, 8'h30);

        // Data strobe ignored in REVIEW, terminator returns to COLLECT
        strobe(4'h7, 4'h7);
        check_eq("ign_count", {5'd0, count}, 8'h02);
        check_eq("ign_mode",  {7'd0, mode},  8'h01);
        strobe(4'h0, 4'h0);
        check_eq("ret_mode",  {7'd0, mode},  8'h00);
        check_eq("ret_count", {5'd0, count}, 8'h00);
        step(1);
        check_eq("ret_H6", {1'b0, H6}, 8'h46);
        check_eq("ret_H5", {1'b0, H5}, 8'h40);
        check_eq("ret_H4", {1'b0, H4}, 8'h7F);
        check_eq("ret_H3", {1'b0, H3}, 8'h7F);
        check_eq("ret_H2", {1'b0, H2}, 8'h7F);
        check_eq("ret_H1", {1'b0, H1}, 8'h7F);

        // Terminator with nothing stored is ignored
        strobe(4'h0, 4'h0);
        check_eq("t0_mode",  {7'd0, mode},  8'h00);
        check_eq("t0_count", {5'd0, count}, 8'h00);
        step(1);
        check_eq("t0_mode2", {7'd0, mode}, 8'h00);

        // Four back-to-back pairs: automatic entry into REVIEW
        strobe(4'h1, 4'h1);
        strobe(4'h2, 4'h2);
        strobe(4'h3, 4'h3);
        strobe(4'h4, 4'h4);
        check_eq("f_count", {5'd0, count}, 8'h04);
        check_eq("f_mode0", {7'd0, mode},  8'h00);
        step(1);
        check_eq("f_mode1", {7'd0, mode}, 8'h01);
        check_eq("f_H4",    {1'b0, H4},   8'h19);
        check_eq("f_H6c",   {1'b0, H6},   8'h46);
        step(1);
        check_eq("f0_H6", {1'b0, H6}, 8'h40);
        check_eq("f0_H1", {1'b0, H1}, 8'h24);
        step(4);
        check_eq("f1_H6", {1'b0, H6}, 8'h79);
        check_eq("f1_H1", {1'b0, H1}, 8'h19);
        step(4);
        check_eq("f2_H6", {1'b0, H6}, 8'h24);
        step(4);
        check_eq("f3_H6", {1'b0, H6}, 8'h30);
        check_eq("f3_H2", {1'b0, H2}, 8'h40);
        check_eq("f3_H1", {1'b0, H1}, 8'h00);
        step(4);
        check_eq("f4_H6", {1'b0, H6}, 8'h40);

        // Reset in the same cycle as a data strobe
        strobe(4'h0, 4'h0);
        check_eq("x_mode", {7'd0, mode}, 8'h00);
        strobe(4'h5, 4'h6);
        check_eq("x_count1", {5'd0, count}, 8'h01);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_x     = 4'h9;
        in_y     = 4'h9;
        step(1);
        reset    = 1'b0;
        in_valid = 1'b0;
        in_x     = 4'h0;
        in_y     = 4'h0;
        check_eq("x_count0", {5'd0, count}, 8'h00);
        step(1);
        check_eq("x_H4", {1'b0, H4}, 8'h7F);
        check_eq("x_H5", {1'b0, H5}, 8'h40);

        // Reset mid-REVIEW discards the pairs
        strobe(4'h2, 4'h3);
        strobe(4'h0, 4'h0);
        check_eq("m_mode1", {7'd0, mode}, 8'h01);
        do_reset();
        check_eq("m_mode0", {7'd0, mode},  8'h00);
        check_eq("m_count", {5'd0, count}, 8'h00);
        check_eq("m_H6",    {1'b0, H6},    8'h46);
        check_eq("m_H3",    {1'b0, H3},    8'h7F);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Stop a runaway simulation.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
